pulse_train_decoder: RTL



---
 rtl/pulse_train_decoder.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/pulse_train_decoder.sv
`default_nettype none
// ============================================================================
// Module   : pulse_train_decoder
// Purpose  : Recovers pulses-per-set and sets-per-train from the generator's
//            serial pulse line; optional expected-count check (PTD_CHECK_EN).
// Revision : 1.0 - initial release
// ============================================================================
module pulse_train_decoder #(
    parameter int CW       = 4,
    parameter int GAP_LOW  = 2,
    parameter int IDLE_LOW = 6
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    input  logic          pulse_in,
    input  logic [CW-1:0] exp_pulses,
    input  logic [CW-1:0] exp_sets,
    output logic          set_valid,
    output logic [CW-1:0] set_pulses,
    output logic          train_done,
    output logic [CW-1:0] train_sets,
    output logic          busy,
    output logic          overflow,
    output logic          mismatch
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HIGH = 2'd1,
        S_LOW  = 2'd2
    } state_t;

    localparam logic [3:0]    c_GAP_LOW  = 4'(GAP_LOW);
    localparam logic [3:0]    c_IDLE_LOW = 4'(IDLE_LOW);
    localparam logic [CW-1:0] c_CNT_MAX  = '1;
    localparam logic [CW-1:0] c_CNT_ONE  = CW'(1);

    state_t        r_state, w_state_next;
    logic [CW-1:0] r_pcnt, w_pcnt_next;
    logic [CW-1:0] r_scnt, w_scnt_next;
    logic [3:0]    r_lowrun, w_lowrun_next, w_lowrun_inc;
    logic          r_overflow, w_overflow_next;
    logic          w_set_close, w_train_close, w_train_start;
    logic          r_set_valid, r_train_done;
    logic [CW-1:0] r_set_pulses, r_train_sets;

    always_comb begin
        w_state_next    = r_state;
        w_pcnt_next     = r_pcnt;
        w_scnt_next     = r_scnt;
        w_lowrun_next   = r_lowrun;
        w_overflow_next = r_overflow;
        w_set_close     = 1'b0;
        w_train_close   = 1'b0;
        w_train_start   = 1'b0;
        w_lowrun_inc    = (r_lowrun == 4'hF) ? r_lowrun : r_lowrun + 4'd1;

        case (r_state)
            S_IDLE: begin
                if (pulse_in) begin
                    w_state_next    = S_HIGH;
                    w_pcnt_next     = c_CNT_ONE;
                    w_scnt_next     = '0;
                    w_lowrun_next   = 4'd0;
                    w_overflow_next = 1'b0;
                    w_train_start   = 1'b1;
                end
            end
            S_HIGH: begin
                // A long high level is still one pulse; only the fall matters.
                if (!pulse_in) begin
                    w_state_next  = S_LOW;
                    w_lowrun_next = 4'd1;
                end
            end
            S_LOW: begin
                if (pulse_in) begin
                    w_state_next  = S_HIGH;
                    w_lowrun_next = 4'd0;
                    if (r_lowrun < c_GAP_LOW) begin
                        if (r_pcnt == c_CNT_MAX) begin
                            w_overflow_next = 1'b1;
                        end else begin
                            w_pcnt_next = r_pcnt + c_CNT_ONE;
                        end
                    end else begin
                        w_pcnt_next = c_CNT_ONE;
                    end
                end else begin
                    w_lowrun_next = w_lowrun_inc;
                    if (w_lowrun_inc == c_GAP_LOW) begin
                        w_set_close = 1'b1;
                        if (r_scnt == c_CNT_MAX) begin
                            w_overflow_next = 1'b1;
                        end else begin
                            w_scnt_next = r_scnt + c_CNT_ONE;
                        end
                    end
                    if (w_lowrun_inc == c_IDLE_LOW) begin
                        w_train_close = 1'b1;
                        w_state_next  = S_IDLE;
                    end
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_pcnt       <= '0;
            r_scnt       <= '0;
            r_lowrun     <= 4'd0;
            r_overflow   <= 1'b0;
            r_set_valid  <= 1'b0;
            r_train_done <= 1'b0;
            r_set_pulses <= '0;
            r_train_sets <= '0;
        end else begin
            // Strobes self-clear on every clock, enabled or not.
            r_set_valid  <= 1'b0;
            r_train_done <= 1'b0;
            if (enable) begin
                r_state    <= w_state_next;
                r_pcnt     <= w_pcnt_next;
                r_scnt     <= w_scnt_next;
                r_lowrun   <= w_lowrun_next;
                r_overflow <= w_overflow_next;
                if (w_set_close) begin
                    r_set_valid  <= 1'b1;
                    r_set_pulses <= r_pcnt;
                end
                if (w_train_close) begin
                    r_train_done <= 1'b1;
                    r_train_sets <= r_scnt;
                end
            end
        end
    end

`ifdef PTD_CHECK_EN
    logic r_mismatch;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mismatch <= 1'b0;
        end else if (enable) begin
            if (w_train_start) begin
                r_mismatch <= 1'b0;
            end else if ((w_set_close && (r_pcnt != exp_pulses)) ||
                         (w_train_close && (r_scnt != exp_sets))) begin
                r_mismatch <= 1'b1;
            end
        end
    end

    assign mismatch = r_mismatch;
`else
    logic w_unused_exp;
    assign w_unused_exp = ^{exp_pulses, exp_sets};
    assign mismatch     = 1'b0;
`endif

    assign set_valid  = r_set_valid;
    assign set_pulses = r_set_pulses;
    assign train_done = r_train_done;
    assign train_sets = r_train_sets;
    assign busy       = (r_state != S_IDLE);
    assign overflow   = r_overflow;

endmodule
`default_nettype wire
